// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: per-button FSM states,
// default timing constants and a counter-width helper.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned DEF_N_BTN           = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms at 100 MHz
  localparam int unsigned DEF_HOLD_DELAY      = 50_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms

  // Bits needed to hold every value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One push-button: 2-flop synchronizer, debounce/hold/auto-repeat FSM and its
// counters. Hold and repeat counters only advance on cycles the button reads high.
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_DELAY      = DEF_HOLD_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_DELAY);
  localparam int unsigned REP_W  = cnt_width(REPEAT_PERIOD);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_DELAY);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD - 1);
  localparam bit                DB_ONE    = (DEBOUNCE_CYCLES == 1);

  logic              sync1_q, sync2_q;
  btn_state_e        state_q, state_d;
  btn_state_e        origin_q, origin_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              step_q, step_d;

  logic              advance;
  btn_state_e        adv_state;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      origin_q  <= ST_HELD;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      origin_q  <= origin_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    db_cnt_d  = db_cnt_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    advance   = 1'b0;
    adv_state = state_q;

    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          db_cnt_d = DB_W'(1);
          if (DB_ONE) begin
            state_d = ST_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            step_d  = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            state_d = ST_PRESS_WAIT;
          end
        end
      end

      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          step_d  = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      ST_HELD, ST_REPEAT: begin
        if (!sync2_q) begin
          origin_d = state_q;
          db_cnt_d = DB_W'(1);
          if (DB_ONE) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = ST_RELEASE_WAIT;
          end
        end else begin
          advance = 1'b1;
        end
      end

      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          // Glitch rejected: resume the interrupted phase, counting this high cycle.
          state_d   = origin_q;
          advance   = 1'b1;
          adv_state = origin_q;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (adv_state == ST_HELD) begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
          if (REPEAT_EN && (hold_q == HOLD_LAST)) begin
            state_d = ST_REPEAT;
            step_d  = 1'b1;
            rep_d   = '0;
          end
        end
      end else if (rep_q == REP_LAST) begin
        rep_d  = '0;
        step_d = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN bouncing push-buttons into debounced levels plus registered
// press, release and step (press or auto-repeat) pulses, one FSM per button.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned      N_BTN           = DEF_N_BTN,
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned      HOLD_DELAY      = DEF_HOLD_DELAY,
  parameter int unsigned      REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_EN       = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] step_pulse
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_DELAY     (HOLD_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_EN[g])
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[g]),
      .level_o  (btn_level[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .step_o   (step_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a run-length model of the debounce and
// hold/repeat rules is checked every cycle, plus literal edge-indexed expectations.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int RP   = 5;
  localparam int NB   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;

  logic [NB-1:0] level_a, press_a, release_a, step_a;
  logic [NB-1:0] level_b, press_b, release_b, step_b;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_DELAY(HOLD),
    .REPEAT_PERIOD(RP), .REPEAT_EN(2'b11)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(level_a), .press_pulse(press_a),
    .release_pulse(release_a), .step_pulse(step_a)
  );

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_DELAY(HOLD),
    .REPEAT_PERIOD(RP), .REPEAT_EN(2'b10)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(level_b), .press_pulse(press_b),
    .release_pulse(release_b), .step_pulse(step_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the FSM sees raw delayed by two edges; a level flips after DB
  // consecutive samples disagreeing with it; h counts high samples since press.
  logic [1:0] m_en [2];
  logic       m_s1 [2][NB], m_s2 [2][NB], m_lvl [2][NB];
  int         m_run [2][NB], m_h [2][NB];
  logic       m_pp [2][NB], m_rp [2][NB], m_sp [2][NB];
  logic       m_sv;
  logic       model_on = 1'b0;

  initial begin
    m_en[0] = 2'b11;
    m_en[1] = 2'b10;
  end

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NB; i++) begin
        if (rst) begin
          m_s1[j][i] = 1'b0; m_s2[j][i] = 1'b0; m_lvl[j][i] = 1'b0;
          m_run[j][i] = 0;   m_h[j][i] = 0;
          m_pp[j][i] = 1'b0; m_rp[j][i] = 1'b0; m_sp[j][i] = 1'b0;
        end else begin
          m_sv = m_s2[j][i];
          m_pp[j][i] = 1'b0; m_rp[j][i] = 1'b0; m_sp[j][i] = 1'b0;
          if (m_sv != m_lvl[j][i]) begin
            m_run[j][i]++;
            if (m_run[j][i] == DB) begin
              m_lvl[j][i] = m_sv;
              m_run[j][i] = 0;
              if (m_sv) begin
                m_pp[j][i] = 1'b1; m_sp[j][i] = 1'b1; m_h[j][i] = 0;
              end else begin
                m_rp[j][i] = 1'b1;
              end
            end
          end else begin
            m_run[j][i] = 0;
            if (m_lvl[j][i]) begin
              m_h[j][i]++;
              if (m_en[j][i] && m_h[j][i] >= HOLD && ((m_h[j][i] - HOLD) % RP) == 0)
                m_sp[j][i] = 1'b1;
            end
          end
          m_s2[j][i] = m_s1[j][i];
          m_s1[j][i] = btn_raw[i];
        end
      end
    end
    if (rst) model_on = 1'b1;
  end

  function automatic logic [NB-1:0] pack(input logic v [NB]);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = v[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      check("a_level",   level_a,   pack(m_lvl[0]));
      check("a_press",   press_a,   pack(m_pp[0]));
      check("a_release", release_a, pack(m_rp[0]));
      check("a_step",    step_a,    pack(m_sp[0]));
      check("b_level",   level_b,   pack(m_lvl[1]));
      check("b_press",   press_b,   pack(m_pp[1]));
      check("b_release", release_b, pack(m_rp[1]));
      check("b_step",    step_b,    pack(m_sp[1]));
    end
  end

  // Edge-indexed event logs for button 0 (edge 0 = first tick of a scenario).
  int ek;
  int press_q[$], rel_q[$], step_q[$], step_nr_q[$];

  task automatic clear_logs();
    ek = 0;
    press_q.delete(); rel_q.delete(); step_q.delete(); step_nr_q.delete();
  endtask

  task automatic tick(input logic [1:0] raw_v, input logic rst_v);
    @(negedge clk);
    btn_raw = raw_v;
    rst     = rst_v;
    @(posedge clk);
    #1;
    if (press_a[0])   press_q.push_back(ek);
    if (release_a[0]) rel_q.push_back(ek);
    if (step_a[0])    step_q.push_back(ek);
    if (step_b[0])    step_nr_q.push_back(ek);
    ek++;
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  task automatic release_all();
    for (int k = 0; k < 10; k++) tick(2'b00, 1'b0);
  endtask

  int exp_q[$];

  initial begin
    btn_raw = '0;
    rst     = 1'b1;
    for (int k = 0; k < 3; k++) tick(2'b00, 1'b1);
    check("rst_outputs", {level_a, press_a, release_a, step_a}, 8'h00);
    for (int k = 0; k < 3; k++) tick(2'b00, 1'b0);

    // Clean press on button 0.
    clear_logs();
    for (int k = 0; k < 9; k++) begin
      tick(2'b01, 1'b0);
      check($sformatf("clean_press_e%0d", k), press_a[0], (k == 5));
      check($sformatf("clean_step_e%0d", k),  step_a[0],  (k == 5));
      check($sformatf("clean_level_e%0d", k), level_a[0], (k >= 5));
    end
    clear_logs();
    release_all();
    exp_q = '{5};
    check_list("release_once", rel_q, exp_q);
    check("release_level", level_a[0], 1'b0);

    // Bounce: 1,0,1,0... for 10 edges, then steady high.
    clear_logs();
    for (int k = 0; k < 10; k++) tick((k % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
    for (int k = 0; k < 8; k++) tick(2'b01, 1'b0);
    exp_q = '{15};
    check_list("bounce_press", press_q, exp_q);
    release_all();

    // Auto-repeat with a 2-cycle release glitch at edges 63..64.
    clear_logs();
    for (int k = 0; k < 76; k++) tick((k == 63 || k == 64) ? 2'b00 : 2'b01, 1'b0);
    exp_q = '{5, 25, 30, 35, 40, 45, 50, 55, 60, 67, 72};
    check_list("repeat_steps", step_q, exp_q);
    exp_q = '{5};
    check_list("norepeat_steps", step_nr_q, exp_q);
    exp_q.delete();
    check_list("glitch_no_release", rel_q, exp_q);
    release_all();

    // Reset while HELD, then re-press.
    clear_logs();
    for (int k = 0; k < 10; k++) tick(2'b01, 1'b0);
    tick(2'b01, 1'b1);
    tick(2'b01, 1'b1);
    check("rst_held_outputs", {level_a, press_a, release_a, step_a}, 8'h00);
    exp_q.delete();
    check_list("rst_no_release", rel_q, exp_q);
    clear_logs();
    for (int k = 0; k < 8; k++) tick(2'b01, 1'b0);
    exp_q = '{5};
    check_list("repress_after_rst", press_q, exp_q);
    release_all();

    // Both buttons rise on the same edge.
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      tick(2'b11, 1'b0);
      check($sformatf("concurrent_press_e%0d", k), press_a, (k == 5) ? 2'b11 : 2'b00);
    end
    release_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of independent push-buttons.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz), legal range 1..2^24-1.
REQ-003 SHALL have parameter HOLD_DELAY, default 50_000_000, cycles a press is held before auto-repeat begins, legal range 1..2^28-1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10_000_000, cycles between auto-repeat pulses, legal range 1..2^28-1.
REQ-005 SHALL have parameter REPEAT_EN, default all ones, N_BTN-bit mask; bit i=0 disables auto-repeat for button i.
REQ-006 clk  input  1  system clock, 100 MHz.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 btn_raw  input  N_BTN  asynchronous, bouncing button levels, 1 = pressed.
REQ-009 btn_level  output  N_BTN  debounced level per button.
REQ-010 press_pulse  output  N_BTN  one-cycle pulse on accepted press.
REQ-011 release_pulse  output  N_BTN  one-cycle pulse on accepted release.
REQ-012 step_pulse  output  N_BTN  press_pulse OR auto-repeat pulse; drives downstream up/down speed stepping.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync) SHALL feed the FSM.
REQ-014 Each button SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
REQ-015 IDLE: sync=1 -> PRESS_WAIT, stability counter cleared to 1.
REQ-016 PRESS_WAIT: sync=0 -> IDLE with no pulse; sync=1 increments the counter; the cycle the counter reaches DEBOUNCE_CYCLES -> HELD, btn_level=1, press_pulse=1 and step_pulse=1 for exactly one cycle, hold counter cleared.
REQ-017 Timing: with raw held high and first sampled high at clock edge 0, press_pulse SHALL be high in the cycle following edge DEBOUNCE_CYCLES+1, never earlier.
REQ-018 HELD: hold counter increments per cycle; on reaching HOLD_DELAY with REPEAT_EN[i]=1 -> REPEAT, step_pulse=1 one cycle, repeat counter cleared; with REPEAT_EN[i]=0 SHALL saturate and stay HELD.
REQ-019 REPEAT: step_pulse=1 for one cycle each time the repeat counter reaches REPEAT_PERIOD, then counter clears; pulses continue indefinitely while held.
REQ-020 HELD or REPEAT: sync=0 -> RELEASE_WAIT, origin state recorded, hold/repeat counters frozen, no step pulses emitted.
REQ-021 RELEASE_WAIT: sync=1 before DEBOUNCE_CYCLES consecutive low cycles -> return to origin state, counters resume from frozen value; DEBOUNCE_CYCLES consecutive low -> IDLE, btn_level=0, release_pulse=1 one cycle.
REQ-022 press_pulse, release_pulse, step_pulse SHALL be registered outputs, never high more than one consecutive cycle per event.
REQ-023 Counters SHALL be sized from their parameters via $clog2 and SHALL never wrap.
REQ-024 Simultaneous events on different buttons SHALL be reported in the same cycle, independently.

Reset
REQ-025 rst SHALL force every FSM to IDLE, clear all counters and synchronizer flops, drive btn_level, press_pulse, release_pulse, step_pulse to 0 from the next cycle.
REQ-026 rst asserted mid-press SHALL emit no release_pulse; a button still held after rst deasserts SHALL produce a fresh press_pulse after the full debounce latency.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-028 A single-button sub-module btn_debounce_fsm (synchronizer, FSM, counters) SHALL be instantiated N_BTN times by a generate loop.

Verification (bench params DEBOUNCE_CYCLES=4, HOLD_DELAY=20, REPEAT_PERIOD=5, N_BTN=2)
REQ-029 Clean press: raw[0] 0->1 sampled at edge 0, held -> press_pulse[0]=step_pulse[0]=1 only in the cycle after edge 5, btn_level[0]=1 from then.
REQ-030 Bounce: raw[0] toggles 1,0,1,0 every cycle for 10 cycles then stays 1 -> exactly one press_pulse, 6 cycles after last rising sample.
REQ-031 Auto-repeat: hold raw[0] 60 cycles -> step pulses at press, press+20, then every 5 cycles (press+25, +30, ...); with REPEAT_EN=2'b10 only the press step.
REQ-032 Release glitch: while in REPEAT, raw low 2 cycles then high -> no release_pulse, repeat cadence resumes shifted by the glitch length.
REQ-033 Release and reset: raw low 10 cycles -> one release_pulse; separately, rst during HELD -> all outputs 0, no release_pulse, re-press after rst produces press_pulse 6 cycles later.
REQ-034 Concurrency: raw[0] and raw[1] rise at the same edge -> press_pulse=2'b11 in the same cycle.
